// File: rtl/truth_table_scanner.sv
// Purpose : exhaustive stimulus/capture wrapper that walks a 2^N_IN-entry truth table
//           through a combinational cell and grades it against an expected minterm mask.
// Latency : done pulses 2^N_IN*(SETTLE+1) cycles after start is accepted; one-cycle pulse.
// Backpr. : none; start is honoured only in IDLE, ignored (not queued) while scanning or in DONE.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   start, expected  begin a scan; expected truth table captured on acceptance
//   abcd_out, s_in   registered stimulus to the cell (MSB = a) and the cell's output
//   busy, done       scan in progress; one-cycle completion pulse
//   table_out        captured truth table, bit i = s_in for index i
//   match            captured table equals expected (valid from done)
//   mismatch_count   number of differing indices
//   first_fail       lowest differing index, fail_valid = at least one difference
module truth_table_scanner #(
  parameter int N_IN   = 4,
  parameter int SETTLE = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [(1<<N_IN)-1:0]   expected,
  output logic [N_IN-1:0]        abcd_out,
  input  logic                   s_in,
  output logic                   busy,
  output logic                   done,
  output logic [(1<<N_IN)-1:0]   table_out,
  output logic                   match,
  output logic [N_IN:0]          mismatch_count,
  output logic [N_IN-1:0]        first_fail,
  output logic                   fail_valid
);

  localparam int NV = 1 << N_IN;
  // Wait counter must hold SETTLE; keep at least one bit when SETTLE is 0.
  localparam int WW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
  localparam logic [WW-1:0]   SETTLE_W = WW'(SETTLE);
  localparam logic [N_IN-1:0] LAST_IDX = N_IN'(NV - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state_q,  state_d;
  logic [N_IN-1:0]   idx_q,    idx_d;
  logic [N_IN-1:0]   abcd_q,   abcd_d;
  logic [WW-1:0]     wait_q,   wait_d;
  logic [NV-1:0]     exp_q,    exp_d;
  logic [NV-1:0]     tbl_q,    tbl_d;
  logic [N_IN:0]     mcount_q, mcount_d;
  logic [N_IN-1:0]   ffail_q,  ffail_d;
  logic              fvld_q,   fvld_d;
  logic              busy_q,   busy_d;
  logic              done_q,   done_d;
  logic              match_q,  match_d;
  logic              miss;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    abcd_d   = abcd_q;
    wait_d   = wait_q;
    exp_d    = exp_q;
    tbl_d    = tbl_q;
    mcount_d = mcount_q;
    ffail_d  = ffail_q;
    fvld_d   = fvld_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    match_d  = match_q;
    miss     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          exp_d    = expected;
          idx_d    = '0;
          abcd_d   = '0;
          wait_d   = '0;
          tbl_d    = '0;
          mcount_d = '0;
          ffail_d  = '0;
          fvld_d   = 1'b0;
          match_d  = 1'b0;
          busy_d   = 1'b1;
          state_d  = S_SCAN;
        end
      end

      S_SCAN: begin
        if (wait_q != SETTLE_W) begin
          wait_d = wait_q + WW'(1);
        end else begin
          // Settle time elapsed: sample this vector's response.
          wait_d       = '0;
          tbl_d[idx_q] = s_in;
          miss         = s_in ^ exp_q[idx_q];
          if (miss) begin
            mcount_d = mcount_q + (N_IN+1)'(1);
            if (!fvld_q) begin
              ffail_d = idx_q;
              fvld_d  = 1'b1;
            end
          end
          if (idx_q == LAST_IDX) begin
            // Final sample must be folded into match explicitly; mcount_q lags it.
            busy_d  = 1'b0;
            done_d  = 1'b1;
            match_d = (mcount_q == '0) && !miss;
            state_d = S_DONE;
          end else begin
            idx_d  = idx_q + N_IN'(1);
            abcd_d = idx_q + N_IN'(1);
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      abcd_q   <= '0;
      wait_q   <= '0;
      exp_q    <= '0;
      tbl_q    <= '0;
      mcount_q <= '0;
      ffail_q  <= '0;
      fvld_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      match_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      abcd_q   <= abcd_d;
      wait_q   <= wait_d;
      exp_q    <= exp_d;
      tbl_q    <= tbl_d;
      mcount_q <= mcount_d;
      ffail_q  <= ffail_d;
      fvld_q   <= fvld_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      match_q  <= match_d;
    end
  end

  assign abcd_out       = abcd_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign table_out      = tbl_q;
  assign match          = match_q;
  assign mismatch_count = mcount_q;
  assign first_fail     = ffail_q;
  assign fail_valid     = fvld_q;

endmodule

// File: tb/tb_truth_table_scanner.sv
// Purpose : self-checking bench for truth_table_scanner, SETTLE=0 and SETTLE=1 instances.
// Latency : n/a (bench).
// Backpr. : n/a (bench).
module tb_truth_table_scanner;

  logic        clk;
  logic        rst_n;

  // Index u of every array is the SETTLE value of the instance it belongs to.
  logic        start_v [2];
  logic [15:0] exp_v   [2];
  logic [3:0]  abcd_v  [2];
  logic        s_v     [2];
  logic        busy_v  [2];
  logic        done_v  [2];
  logic [15:0] tbl_v   [2];
  logic        match_v [2];
  logic [4:0]  mc_v    [2];
  logic [3:0]  ff_v    [2];
  logic        fv_v    [2];

  // Cell behaviour: 0 = reference gate function, 1 = tied high, 2 = random lookup table.
  int          mode;
  logic [15:0] rnd_tbl;

  int n_checks;
  int n_errs;

  truth_table_scanner #(.N_IN(4), .SETTLE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .expected(exp_v[0]),
    .abcd_out(abcd_v[0]), .s_in(s_v[0]), .busy(busy_v[0]), .done(done_v[0]),
    .table_out(tbl_v[0]), .match(match_v[0]), .mismatch_count(mc_v[0]),
    .first_fail(ff_v[0]), .fail_valid(fv_v[0])
  );

  truth_table_scanner #(.N_IN(4), .SETTLE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .expected(exp_v[1]),
    .abcd_out(abcd_v[1]), .s_in(s_v[1]), .busy(busy_v[1]), .done(done_v[1]),
    .table_out(tbl_v[1]), .match(match_v[1]), .mismatch_count(mc_v[1]),
    .first_fail(ff_v[1]), .fail_valid(fv_v[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic cell_out(input int m, input logic [15:0] t, input logic [3:0] v);
    logic a, b, c, d;
    {a, b, c, d} = v;
    if (m == 1)      return 1'b1;
    else if (m == 2) return t[v];
    else             return (~b & c) | (~a & b & ~c) | (a & b & d);
  endfunction

  assign s_v[0] = cell_out(mode, rnd_tbl, abcd_v[0]);
  assign s_v[1] = cell_out(mode, rnd_tbl, abcd_v[1]);

  // Full truth table the cell should produce.
  function automatic logic [15:0] ref_table(input int m, input logic [15:0] t);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) r[i] = cell_out(m, t, 4'(i));
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] all_outs(input int u);
    return {31'd0, abcd_v[u], busy_v[u], done_v[u], tbl_v[u], match_v[u],
            mc_v[u], ff_v[u], fv_v[u]};
  endfunction

  // One scan on instance u; restart_at >= 1 pulses start again at that scan cycle.
  task automatic run_scan(input int u, input logic [15:0] e, input int restart_at, input string tag);
    logic [15:0] et;
    int nm, ffx, lat, seq_err, done_at;
    et  = ref_table(mode, rnd_tbl);
    nm  = $countones(et ^ e);
    ffx = 0;
    for (int i = 15; i >= 0; i--) if (et[i] != e[i]) ffx = i;
    lat = 16 * (u + 1);
    seq_err = 0;
    done_at = -1;

    @(posedge clk); #1;
    start_v[u] = 1'b1;
    exp_v[u]   = e;
    @(posedge clk); #1;   // edge E accepted the start
    start_v[u] = 1'b0;
    if (!busy_v[u] || abcd_v[u] != 4'd0) seq_err++;
    for (int k = 1; k <= lat + 8; k++) begin
      @(posedge clk); #1;
      start_v[u] = (k == restart_at);
      if (done_v[u]) begin
        done_at = k;
        break;
      end
      if (!busy_v[u] || abcd_v[u] != 4'(k / (u + 1))) seq_err++;
    end
    start_v[u] = 1'b0;

    check($sformatf("%s latency", tag), 64'(done_at), 64'(lat));
    check($sformatf("%s stim_seq_errs", tag), 64'(seq_err), 64'd0);
    check($sformatf("%s table", tag), 64'(tbl_v[u]), 64'(et));
    check($sformatf("%s match", tag), 64'(match_v[u]), 64'(nm == 0));
    check($sformatf("%s mismatch_count", tag), 64'(mc_v[u]), 64'(nm));
    check($sformatf("%s first_fail", tag), 64'(ff_v[u]), 64'(ffx));
    check($sformatf("%s fail_valid", tag), 64'(fv_v[u]), 64'(nm != 0));
    check($sformatf("%s busy_at_done", tag), 64'(busy_v[u]), 64'd0);
    @(posedge clk); #1;
    check($sformatf("%s done_one_cycle", tag), 64'(done_v[u]), 64'd0);
    check($sformatf("%s table_hold", tag), 64'(tbl_v[u]), 64'(et));
  endtask

  initial begin
    int idle_err, late_done, b2b_cnt;
    int b2b_at [$];
    n_checks = 0;
    n_errs   = 0;
    mode     = 0;
    rnd_tbl  = '0;
    rst_n    = 1'b0;
    for (int u = 0; u < 2; u++) begin
      start_v[u] = 1'b0;
      exp_v[u]   = '0;
    end

    #2;
    check("reset_outs_s0", all_outs(0), 64'd0);
    check("reset_outs_s1", all_outs(1), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Idle with start low: nothing moves.
    idle_err = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (all_outs(0) != 64'd0 || all_outs(1) != 64'd0) idle_err++;
    end
    check("idle_quiet", 64'(idle_err), 64'd0);

    mode = 0;
    run_scan(1, 16'hAC3C, -1, "pass");
    run_scan(1, 16'hAC3D, -1, "one_fail");
    mode = 1;
    run_scan(1, 16'h0000, -1, "all_fail");
    mode = 0;
    run_scan(1, 16'hAC3C, 10, "start_ignored");

    // Reset in the middle of a scan abandons it immediately.
    @(posedge clk); #1;
    start_v[1] = 1'b1;
    exp_v[1]   = 16'hAC3C;
    @(posedge clk); #1;
    start_v[1] = 1'b0;
    repeat (20) @(posedge clk);
    #3;
    check("pre_reset_busy", 64'(busy_v[1]), 64'd1);
    rst_n = 1'b0;
    #1;
    check("midscan_reset_s1", all_outs(1), 64'd0);
    check("midscan_reset_s0", all_outs(0), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    late_done = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done_v[1] || busy_v[1]) late_done++;
    end
    check("no_done_after_reset", 64'(late_done), 64'd0);

    run_scan(0, 16'hAC3C, -1, "settle0");

    // start held high: back-to-back scans, one done pulse each (16 scan + DONE + IDLE).
    @(posedge clk); #1;
    start_v[0] = 1'b1;
    exp_v[0]   = 16'hAC3C;
    @(posedge clk); #1;
    b2b_cnt = 0;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk); #1;
      if (done_v[0]) begin
        b2b_at.push_back(k);
        if (match_v[0]) b2b_cnt++;
      end
    end
    start_v[0] = 1'b0;
    check("b2b_pulses", 64'(b2b_at.size()), 64'd3);
    check("b2b_matches", 64'(b2b_cnt), 64'd3);
    if (b2b_at.size() == 3) begin
      check("b2b_first", 64'(b2b_at[0]), 64'd16);
      check("b2b_gap1", 64'(b2b_at[1] - b2b_at[0]), 64'd18);
      check("b2b_gap2", 64'(b2b_at[2] - b2b_at[1]), 64'd18);
    end
    repeat (40) @(posedge clk);

    // Random cells and expected masks on both instances.
    mode = 2;
    for (int it = 0; it < 8; it++) begin
      logic [15:0] e;
      int u;
      rnd_tbl = 16'($urandom);
      u = int'($urandom_range(0, 1));
      case ($urandom_range(0, 2))
        0:       e = rnd_tbl;
        1:       e = rnd_tbl ^ (16'd1 << $urandom_range(0, 15));
        default: e = 16'($urandom);
      endcase
      run_scan(u, e, -1, $sformatf("rand%0d", it));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
